// File: rtl/scrypt_nonce_feeder_pkg.sv
// Shared widths and FSM state type for the scrypt nonce feeder.
package scrypt_nonce_feeder_pkg;

  localparam int unsigned HDR_W     = 640;
  localparam int unsigned NONCE_W   = 32;
  localparam int unsigned PREFIX_W  = HDR_W - NONCE_W;
  localparam int unsigned NONCE_LSB = 608;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StDone
  } feeder_state_t;

endpackage

// File: rtl/scrypt_nonce_feeder.sv
// Job sequencer for scrypt_top: walks a nonce range one hash at a time and
// stops on the first match or when the inclusive end nonce has been tried.
module scrypt_nonce_feeder
  import scrypt_nonce_feeder_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [PREFIX_W-1:0] i_header_in,
  input  logic [NONCE_W-1:0]  i_nonce_start,
  input  logic [NONCE_W-1:0]  i_nonce_end,
  output logic                o_core_enable,
  output logic [HDR_W-1:0]    o_core_data,
  input  logic                i_core_hash_done,
  input  logic                i_core_match_found,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_found,
  output logic [NONCE_W-1:0]  o_found_nonce,
  output logic                o_exhausted,
  output logic [NONCE_W-1:0]  o_hashes_tried
);

  feeder_state_t       r_state;
  logic [PREFIX_W-1:0] r_prefix;
  logic [NONCE_W-1:0]  r_nonce_cur;
  logic [NONCE_W-1:0]  r_end;
  logic                r_core_enable;
  logic                r_done;
  logic                r_found;
  logic [NONCE_W-1:0]  r_found_nonce;
  logic                r_exhausted;
  logic [NONCE_W-1:0]  r_hashes;

  logic [NONCE_W-1:0]  w_hashes_inc;
  logic                w_last;

  assign w_hashes_inc = (r_hashes == '1) ? r_hashes : r_hashes + NONCE_W'(1);
  assign w_last       = (r_nonce_cur == r_end);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_prefix      <= '0;
      r_nonce_cur   <= '0;
      r_end         <= '0;
      r_core_enable <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_exhausted   <= 1'b0;
      r_hashes      <= '0;
    end else begin
      r_core_enable <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start && !i_abort) begin
            r_prefix      <= i_header_in;
            r_nonce_cur   <= i_nonce_start;
            r_end         <= i_nonce_end;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_exhausted   <= 1'b0;
            r_hashes      <= '0;
            r_core_enable <= 1'b1;
            r_state       <= StLaunch;
          end
        end
        StLaunch: begin
          r_state <= i_abort ? StIdle : StWait;
        end
        StWait: begin
          // abort wins over a completion arriving in the same cycle
          if (i_abort) begin
            r_state <= StIdle;
          end else if (i_core_hash_done) begin
            r_hashes <= w_hashes_inc;
            if (i_core_match_found) begin
              r_found       <= 1'b1;
              r_found_nonce <= r_nonce_cur;
              r_done        <= 1'b1;
              r_state       <= StDone;
            end else if (w_last) begin
              r_exhausted <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_nonce_cur   <= r_nonce_cur + NONCE_W'(1);
              r_core_enable <= 1'b1;
              r_state       <= StLaunch;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_core_enable  = r_core_enable;
  assign o_core_data    = {r_nonce_cur, r_prefix};
  assign o_busy         = (r_state != StIdle);
  assign o_done         = r_done;
  assign o_found        = r_found;
  assign o_found_nonce  = r_found_nonce;
  assign o_exhausted    = r_exhausted;
  assign o_hashes_tried = r_hashes;

endmodule

// File: tb/tb_scrypt_nonce_feeder.sv
// Scoreboard bench for scrypt_nonce_feeder with a behavioural scrypt core model.
module tb_scrypt_nonce_feeder;

  localparam int unsigned HdrW    = 640;
  localparam int unsigned NonceW  = 32;
  localparam int unsigned PrefixW = 608;

  typedef struct {
    logic        found;
    logic [31:0] found_nonce;
    logic        exhausted;
    logic [31:0] hashes;
  } res_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [PrefixW-1:0] header_in;
  logic [NonceW-1:0]  nonce_start;
  logic [NonceW-1:0]  nonce_end;
  logic               core_enable;
  logic [HdrW-1:0]    core_data;
  logic               hash_done;
  logic               match_found;
  logic               busy;
  logic               done;
  logic               found;
  logic [NonceW-1:0]  found_nonce;
  logic               exhausted;
  logic [NonceW-1:0]  hashes_tried;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0]        exp_launch[$];
  res_t               exp_res[$];
  logic [PrefixW-1:0] cur_prefix;

  // core model state
  logic        match_en;
  logic [31:0] match_nonce;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_nonce;

  scrypt_nonce_feeder u_dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_abort            (abort),
    .i_header_in        (header_in),
    .i_nonce_start      (nonce_start),
    .i_nonce_end        (nonce_end),
    .o_core_enable      (core_enable),
    .o_core_data        (core_data),
    .i_core_hash_done   (hash_done),
    .i_core_match_found (match_found),
    .o_busy             (busy),
    .o_done             (done),
    .o_found            (found),
    .o_found_nonce      (found_nonce),
    .o_exhausted        (exhausted),
    .o_hashes_tried     (hashes_tried)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural core: hash_done 20 cycles after enable, match on match_nonce.
  initial begin
    hash_done   = 1'b0;
    match_found = 1'b0;
    m_pend      = 1'b0;
    m_cnt       = 0;
    m_nonce     = '0;
    forever begin
      @(posedge clk);
      #1;
      hash_done   = 1'b0;
      match_found = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          hash_done   = 1'b1;
          match_found = match_en && (m_nonce == match_nonce);
          m_pend      = 1'b0;
        end
      end
      if (core_enable) begin
        m_pend  = 1'b1;
        m_cnt   = 20;
        m_nonce = core_data[639:608];
      end
    end
  end

  // Monitor: launches, results, launch turnaround and core_data stability.
  initial begin
    int          cyc = 0;
    bit          gap_valid = 0;
    logic [HdrW-1:0] held = '0;
    logic [31:0] e;
    res_t        r;
    forever begin
      @(negedge clk);
      cyc++;
      if (core_enable) begin
        if (exp_launch.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_launch: got nonce %0h expected no launch", core_data[639:608]);
        end else begin
          e = exp_launch.pop_front();
          chk("launch_nonce", 64'(core_data[639:608]), 64'(e));
          n_chk++;
          if (core_data[607:0] !== cur_prefix) begin
            n_fail++;
            $display("FAIL launch_prefix: got %h expected %h", core_data[607:0], cur_prefix);
          end
        end
        if (gap_valid) chk("launch_gap", 64'(cyc), 64'd1);
        gap_valid = 0;
        held = core_data;
      end else if (busy) begin
        n_chk++;
        if (core_data !== held) begin
          n_fail++;
          $display("FAIL data_stable: got nonce %0h expected nonce %0h",
                   core_data[639:608], held[639:608]);
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          r = exp_res.pop_front();
          chk("res_found", 64'(found), 64'(r.found));
          chk("res_found_nonce", 64'(found_nonce), 64'(r.found_nonce));
          chk("res_exhausted", 64'(exhausted), 64'(r.exhausted));
          chk("res_hashes", 64'(hashes_tried), 64'(r.hashes));
        end
        gap_valid = 0;
      end
      if (hash_done && busy && !abort) begin
        cyc = 0;
        gap_valid = 1;
      end
      if (abort || rst || start) gap_valid = 0;
    end
  end

  task automatic start_search(input logic [PrefixW-1:0] hdr, input logic [31:0] s,
                              input logic [31:0] e);
    @(posedge clk);
    #2;
    cur_prefix  = hdr;
    header_in   = hdr;
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_launch(input string nm, input logic [31:0] n);
    bit got = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (core_enable && core_data[639:608] == n) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_launch_seen"}, 64'(got), 64'd1);
  endtask

  function automatic res_t mk_res(input logic f, input logic [31:0] fn, input logic ex,
                                  input logic [31:0] h);
    res_t r;
    r.found = f;
    r.found_nonce = fn;
    r.exhausted = ex;
    r.hashes = h;
    return r;
  endfunction

  initial begin
    logic [PrefixW-1:0] hdr_inc;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    header_in   = '0;
    nonce_start = '0;
    nonce_end   = '0;
    match_en    = 1'b0;
    match_nonce = '0;
    cur_prefix  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_enable", 64'(core_enable), 64'd0);
    chk("rst_core_data", 64'(|core_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_found_nonce", 64'(found_nonce), 64'd0);
    chk("rst_exhausted", 64'(exhausted), 64'd0);
    chk("rst_hashes", 64'(hashes_tried), 64'd0);

    // 1: single-nonce range, no match
    exp_launch.push_back(32'h5);
    exp_res.push_back(mk_res(1'b0, 32'h0, 1'b1, 32'd1));
    start_search({76{8'h01}}, 32'h5, 32'h5);
    wait_done("t1");

    // 2: range 0..9, match at 3
    for (int i = 0; i < 76; i++) hdr_inc[8*i +: 8] = 8'(i);
    match_en    = 1'b1;
    match_nonce = 32'd3;
    for (int i = 0; i < 4; i++) exp_launch.push_back(32'(i));
    exp_res.push_back(mk_res(1'b1, 32'd3, 1'b0, 32'd4));
    start_search(hdr_inc, 32'd0, 32'd9);
    wait_done("t2");
    repeat (30) @(negedge clk);
    chk("t2_idle_after", 64'(busy), 64'd0);

    // 3: wrapping range, no match
    match_en = 1'b0;
    exp_launch.push_back(32'hFFFF_FFFE);
    exp_launch.push_back(32'hFFFF_FFFF);
    exp_launch.push_back(32'h0);
    exp_launch.push_back(32'h1);
    exp_res.push_back(mk_res(1'b0, 32'h0, 1'b1, 32'd4));
    start_search({19{32'hDEAD_BEEF}}, 32'hFFFF_FFFE, 32'h1);
    wait_done("t3");

    // 4: abort in WAIT at nonce 2, stale hash_done afterwards
    for (int i = 0; i < 3; i++) exp_launch.push_back(32'(i));
    start_search({76{8'hA5}}, 32'd0, 32'd9);
    wait_launch("t4", 32'd2);
    repeat (3) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    m_cnt = 5;
    chk("t4_busy_after_abort", 64'(busy), 64'd0);
    chk("t4_found", 64'(found), 64'd0);
    chk("t4_exhausted", 64'(exhausted), 64'd0);
    chk("t4_hashes", 64'(hashes_tried), 64'd2);
    repeat (12) @(negedge clk);
    chk("t4_busy_after_stale", 64'(busy), 64'd0);
    chk("t4_found_after_stale", 64'(found), 64'd0);
    chk("t4_exh_after_stale", 64'(exhausted), 64'd0);
    chk("t4_hashes_after_stale", 64'(hashes_tried), 64'd2);

    // 5: start while busy, then start+abort in IDLE
    exp_launch.push_back(32'd100);
    exp_launch.push_back(32'd101);
    exp_res.push_back(mk_res(1'b0, 32'h0, 1'b1, 32'd2));
    start_search({76{8'h3C}}, 32'd100, 32'd101);
    wait_launch("t5", 32'd100);
    @(posedge clk);
    #2;
    header_in   = {76{8'hFF}};
    nonce_start = 32'd500;
    nonce_end   = 32'd600;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("t5");
    @(posedge clk);
    #2;
    nonce_start = 32'd900;
    start       = 1'b1;
    abort       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_nonce_cur", 64'(core_data[639:608]), 64'd101);
    chk("t5_exhausted", 64'(exhausted), 64'd1);
    chk("t5_hashes", 64'(hashes_tried), 64'd2);

    // reset mid-search
    exp_launch.push_back(32'd7);
    start_search({76{8'h77}}, 32'd7, 32'd8);
    wait_launch("rst", 32'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_core_data", 64'(|core_data), 64'd0);
    chk("mrst_enable", 64'(core_enable), 64'd0);
    repeat (30) @(negedge clk);
    chk("mrst_busy_late", 64'(busy), 64'd0);
    chk("mrst_hashes", 64'(hashes_tried), 64'd0);

    chk("launch_queue_empty", 64'(exp_launch.size()), 64'd0);
    chk("result_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

endmodule
